fcs_tx: RTL and testbench

FCS_TX -- requirements
Module: fcs_tx

---
 rtl/fcs_tx.sv | 148 ++++++++++++++
 tb/tb_fcs_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcs_tx.sv
// rtl/fcs_tx.sv - Ethernet CRC-32 FCS generator for the TX byte mux FCS slot
// Define FCS_TX_PAD_EN to add zero-padding of short frames up to 60 bytes.
module fcs_tx (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       frame_start,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  input  logic       payload_done,
  output logic [7:0] fcs_tx_data,
  output logic       fcs_tx_done,
  output logic       fcs_busy
);

`ifdef FCS_TX_PAD_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SKIP  = 3'd1,
    S_ACCUM = 3'd2,
    S_PAD   = 3'd3,
    S_FCS   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SKIP  = 3'd1,
    S_ACCUM = 3'd2,
    S_FCS   = 3'd4
  } state_t;
`endif

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [10:0] LEN_MAX  = 11'h7FF;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [2:0]  skip_cnt_q, skip_cnt_d;
  logic [10:0] len_q, len_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [10:0] len_inc;
  logic [31:0] fcs_word;

  // Reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + 11'd1;
  assign fcs_word = ~crc_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      crc_q      <= CRC_INIT;
      skip_cnt_q <= 3'd0;
      len_q      <= 11'd0;
      fcs_idx_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      skip_cnt_q <= skip_cnt_d;
      len_q      <= len_d;
      fcs_idx_q  <= fcs_idx_d;
    end
  end

  // frame_start wins in every state, so a mid-frame restart drops the old frame silently.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = S_SKIP;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_SKIP:  if (data_valid && skip_cnt_q == 3'd7) state_d = S_ACCUM;
        S_ACCUM: begin
          if (data_valid && payload_done) begin
`ifdef FCS_TX_PAD_EN
            state_d = (len_inc < 11'd60) ? S_PAD : S_FCS;
`else
            state_d = S_FCS;
`endif
          end
        end
`ifdef FCS_TX_PAD_EN
        S_PAD:   if (len_q == 11'd59) state_d = S_FCS;
`endif
        S_FCS:   if (fcs_idx_q == 2'd3) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    crc_d      = crc_q;
    skip_cnt_d = skip_cnt_q;
    len_d      = len_q;
    fcs_idx_d  = fcs_idx_q;
    if (frame_start) begin
      crc_d      = CRC_INIT;
      skip_cnt_d = 3'd0;
      len_d      = 11'd0;
      fcs_idx_d  = 2'd0;
    end else begin
      case (state_q)
        S_SKIP: begin
          if (data_valid) skip_cnt_d = skip_cnt_q + 3'd1;
        end
        S_ACCUM: begin
          if (data_valid) begin
            crc_d = crc32_byte(crc_q, data_in);
            len_d = len_inc;
          end
        end
`ifdef FCS_TX_PAD_EN
        S_PAD: begin
          crc_d = crc32_byte(crc_q, 8'h00);
          len_d = len_inc;
        end
`endif
        S_FCS:   fcs_idx_d = fcs_idx_q + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    fcs_tx_data = 8'h00;
    fcs_tx_done = 1'b0;
    fcs_busy    = (state_q != S_IDLE);
    if (state_q == S_FCS) begin
      case (fcs_idx_q)
        2'd0:    fcs_tx_data = fcs_word[7:0];
        2'd1:    fcs_tx_data = fcs_word[15:8];
        2'd2:    fcs_tx_data = fcs_word[23:16];
        default: fcs_tx_data = fcs_word[31:24];
      endcase
      fcs_tx_done = (fcs_idx_q == 2'd3);
    end
  end

endmodule

// File: tb/tb_fcs_tx.sv
// tb/tb_fcs_tx.sv - self-checking bench for fcs_tx (table vectors, random frames, abort/reset cases)
// Honours FCS_TX_PAD_EN the same way as the design.
module tb_fcs_tx;

`ifdef FCS_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       frame_start;
  logic       data_valid;
  logic [7:0] data_in;
  logic       payload_done;
  logic [7:0] fcs_tx_data;
  logic       fcs_tx_done;
  logic       fcs_busy;

  fcs_tx dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .frame_start  (frame_start),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .payload_done (payload_done),
    .fcs_tx_data  (fcs_tx_data),
    .fcs_tx_done  (fcs_tx_done),
    .fcs_busy     (fcs_busy)
  );

  always #5 aclk = ~aclk;

  int checks    = 0;
  int errors    = 0;
  int quiet_err = 0;
  int done_cnt  = 0;
  int exp_done  = 0;

  always @(negedge aclk) if (fcs_tx_done === 1'b1) done_cnt <= done_cnt + 1;

  logic [31:0] crc_tbl [256];

  function automatic void build_tbl();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[n] = c;
    end
  endfunction

  function automatic int pad_of(input int len);
    return (PAD_EN && len < 60) ? 60 - len : 0;
  endfunction

  // Table-driven CRC-32 over the frame as it goes on the wire, including any pad zeros.
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
    logic [7:0]  f[$];
    logic [31:0] c;
    f = q;
    for (int i = 0; i < pad_of(q.size()); i++) f.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (f[i]) c = crc_tbl[(c[7:0] ^ f[i])] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic dv, input logic [7:0] d, input logic pd);
    frame_start  = fs;
    data_valid   = dv;
    data_in      = d;
    payload_done = pd;
    @(posedge aclk);
    #1;
  endtask

  task automatic note_quiet();
    if (fcs_tx_data !== 8'h00 || fcs_tx_done !== 1'b0 || fcs_busy !== 1'b1) quiet_err++;
  endtask

  task automatic gaps(input int gap_pct);
    for (int g = 0; g < 3; g++) begin
      if (int'($urandom_range(99)) >= gap_pct) break;
      drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
      note_quiet();
    end
  endtask

  // Start strobe, 7x0x55 + 0xD5, then the payload; payload_done on the last byte if with_done.
  task automatic send_frame(input string nm, input logic [7:0] q[$], input int gap_pct, input bit with_done);
    quiet_err = 0;
    drive(1'b1, 1'b0, 8'($urandom), 1'b0);
    note_quiet();
    for (int i = 0; i < 8; i++) begin
      gaps(gap_pct);
      drive(1'b0, 1'b1, (i == 7) ? 8'hD5 : 8'h55, 1'($urandom));
      note_quiet();
    end
    foreach (q[i]) begin
      gaps(gap_pct);
      if (with_done && i == q.size() - 1) begin
        drive(1'b0, 1'b1, q[i], 1'b1);
      end else begin
        drive(1'b0, 1'b1, q[i], 1'b0);
        note_quiet();
      end
    end
    chk({nm, " quiet"}, 32'(quiet_err), 32'd0);
  endtask

  task automatic expect_tail(input string nm, input int npad, input logic [31:0] fcs);
    for (int i = 0; i < npad; i++) begin
      chk($sformatf("%s pad%0d", nm, i), {23'd0, fcs_busy, fcs_tx_done, fcs_tx_data}, 32'h200);
      drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s fcs%0d", nm, i), {23'd0, fcs_busy, fcs_tx_done, fcs_tx_data},
          {23'd0, 1'b1, (i == 3), fcs[8*i +: 8]});
      drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
    end
    chk({nm, " idle"}, {23'd0, fcs_busy, fcs_tx_done, fcs_tx_data}, 32'h0);
    exp_done++;
  endtask

  typedef struct {
    string       name;
    int          off;
    int          len;
    int          gap;
    int          exp_pad;
    logic [31:0] exp_fcs;
  } vec_t;

  localparam int NV = 8;
  vec_t       vt[NV];
  logic [7:0] pool[$];

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  task automatic add_vec(input int idx, input string nm, input int len, input int gap, input bit ascii);
    logic [7:0] q[$];
    for (int i = 0; i < len; i++) q.push_back(ascii ? 8'(8'h31 + i) : rbyte());
    vt[idx].name    = nm;
    vt[idx].off     = pool.size();
    vt[idx].len     = len;
    vt[idx].gap     = gap;
    vt[idx].exp_pad = pad_of(len);
    vt[idx].exp_fcs = ref_fcs(q);
    foreach (q[i]) pool.push_back(q[i]);
  endtask

  function automatic void get_payload(input int idx, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < vt[idx].len; i++) q.push_back(pool[vt[idx].off + i]);
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] qa[$];
    build_tbl();

    add_vec(0, "ascii9", 9, 0, 1'b1);
`ifndef FCS_TX_PAD_EN
    vt[0].exp_pad = 0;
    vt[0].exp_fcs = 32'hCBF43926;
`endif
    add_vec(1, "arp42",   42,   20, 1'b0);
    add_vec(2, "len59",   59,   0,  1'b0);
    add_vec(3, "len60",   60,   25, 1'b0);
    add_vec(4, "len61",   61,   0,  1'b0);
    add_vec(5, "len1",    1,    30, 1'b0);
    add_vec(6, "len64",   64,   10, 1'b0);
    add_vec(7, "len2050", 2050, 0,  1'b0);

    aresetn = 1'b0;
    frame_start = 1'b0; data_valid = 1'b0; data_in = 8'h00; payload_done = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset outputs", {23'd0, fcs_busy, fcs_tx_done, fcs_tx_data}, 32'h0);
    aresetn = 1'b1;
    drive(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("idle ignores traffic", {23'd0, fcs_busy, fcs_tx_done, fcs_tx_data}, 32'h0);

    for (int v = 0; v < NV; v++) begin
      get_payload(v, q);
      send_frame(vt[v].name, q, vt[v].gap, 1'b1);
      expect_tail(vt[v].name, vt[v].exp_pad, vt[v].exp_fcs);
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      len = int'($urandom_range(1, 120));
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rbyte());
      send_frame($sformatf("rand%0d", r), q, 30, 1'b1);
      expect_tail($sformatf("rand%0d", r), pad_of(len), ref_fcs(q));
    end

    // Frame A aborted mid-payload by frame B's start strobe.
    qa = {};
    for (int i = 0; i < 10; i++) qa.push_back(rbyte());
    send_frame("abortA", qa, 20, 1'b0);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(rbyte());
    send_frame("abortB", q, 20, 1'b1);
    expect_tail("abortB", pad_of(20), ref_fcs(q));

    // Reset pulsed during the second FCS byte.
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(rbyte());
    send_frame("rst", q, 0, 1'b1);
    begin
      logic [31:0] f;
      f = ref_fcs(q);
      chk("rst fcs0", {24'd0, fcs_tx_data}, {24'd0, f[7:0]});
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("rst fcs1", {24'd0, fcs_tx_data}, {24'd0, f[15:8]});
    end
    #1 aresetn = 1'b0;
    #1 chk("rst async outputs", {23'd0, fcs_busy, fcs_tx_done, fcs_tx_data}, 32'h0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    quiet_err = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, rbyte(), (i == 11));
      if (fcs_busy !== 1'b0 || fcs_tx_data !== 8'h00 || fcs_tx_done !== 1'b0) quiet_err++;
    end
    chk("post-reset ignores traffic", 32'(quiet_err), 32'd0);
    q = {};
    for (int i = 0; i < 50; i++) q.push_back(rbyte());
    send_frame("afterrst", q, 15, 1'b1);
    expect_tail("afterrst", pad_of(50), ref_fcs(q));

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("done pulse count", 32'(done_cnt), 32'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
